// File: rtl/vga_capture.sv
// ============================================================================
// vga_capture: samples a VGA stream, measures its timing, qualifies lock and
// emits captured pixels as an (x, y, 12-bit colour) write stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_capture #(
  parameter int MAX_W       = 640,
  parameter int MAX_H       = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        wr_en,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [11:0] px_data,
  output logic [9:0]  h_total_meas,
  output logic [9:0]  v_total_meas,
  output logic [9:0]  h_active_meas,
  output logic [9:0]  v_active_meas,
  output logic        locked,
  output logic        lost_lock
);

  localparam logic [9:0]  TO_LIM = 10'(TIMEOUT);
  localparam logic [10:0] W_LIM  = 11'(MAX_W);
  localparam logic [10:0] H_LIM  = 11'(MAX_H);
  localparam logic [7:0]  LF_LIM = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [7:0]  match_cnt, match_n;
  logic        prev_ld, drop;

  logic        hs1, hs2, vs1, vs2, va1, va2;
  logic [11:0] rgb1, rgb2;
  logic [9:0]  hcnt, x, y, linecnt;
  logic [39:0] prev_meas, cur_meas;
  logic        hfall, vfall, vafall, timeout, same;
  logic [9:0]  x_inc, y_eff, h_tot_new, h_act_new;
  logic        unused_low_bits;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign unused_low_bits = &{1'b0, vga_r[3:0], vga_g[3:0], vga_b[3:0]};

  assign hfall   = hs2 & ~hs1;
  assign vfall   = vs2 & ~vs1;
  assign vafall  = va2 & ~va1;
  assign timeout = !hfall && (hcnt >= TO_LIM);

  // Measurement candidates include updates landing in this same cycle.
  assign x_inc     = sat_inc(x);
  assign y_eff     = vafall ? sat_inc(y) : y;
  assign h_tot_new = hfall ? hcnt : h_total_meas;
  assign h_act_new = vafall ? x_inc : h_active_meas;
  assign cur_meas  = {h_tot_new, linecnt, h_act_new, y_eff};
  assign same      = (cur_meas == prev_meas);

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hs1  <= 1'b0;
      hs2  <= 1'b0;
      vs1  <= 1'b0;
      vs2  <= 1'b0;
      va1  <= 1'b0;
      va2  <= 1'b0;
      rgb1 <= '0;
      rgb2 <= '0;
    end else begin
      hs1  <= hsync;
      vs1  <= vsync;
      va1  <= valid;
      rgb1 <= {vga_r[7:4], vga_g[7:4], vga_b[7:4]};
      hs2  <= hs1;
      vs2  <= vs1;
      va2  <= va1;
      rgb2 <= rgb1;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hcnt          <= '0;
      x             <= '0;
      y             <= '0;
      linecnt       <= '0;
      h_total_meas  <= '0;
      v_total_meas  <= '0;
      h_active_meas <= '0;
      v_active_meas <= '0;
    end else begin
      hcnt <= hfall ? 10'd1 : sat_inc(hcnt);
      if (hfall) h_total_meas <= hcnt;

      if (hfall)    x <= '0;
      else if (va2) x <= x_inc;
      if (vafall)   h_active_meas <= x_inc;

      if (vfall)       y <= '0;
      else if (vafall) y <= sat_inc(y);

      // A coincident hsync edge counts as the first line of the new frame.
      if (vfall) begin
        v_total_meas  <= linecnt;
        v_active_meas <= y_eff;
        linecnt       <= hfall ? 10'd1 : 10'd0;
      end else if (hfall) begin
        linecnt <= sat_inc(linecnt);
      end
    end
  end

  always_comb begin
    state_n = state;
    match_n = match_cnt;
    prev_ld = 1'b0;
    drop    = 1'b0;
    if (timeout) begin
      state_n = SEARCH;
      match_n = '0;
      drop    = (state == LOCKED);
    end else if (vfall) begin
      case (state)
        SEARCH: begin
          state_n = CHECK;
          match_n = '0;
        end
        CHECK: begin
          prev_ld = 1'b1;
          if (same) begin
            match_n = match_cnt + 8'd1;
            if (match_n >= LF_LIM) state_n = LOCKED;
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
          prev_ld = 1'b1;
          if (!same) begin
            state_n = CHECK;
            match_n = '0;
            drop    = 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      match_cnt <= '0;
      prev_meas <= '0;
      locked    <= 1'b0;
      lost_lock <= 1'b0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      if (prev_ld) prev_meas <= cur_meas;
      locked    <= (state_n == LOCKED);
      lost_lock <= drop;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      px_x    <= '0;
      px_y    <= '0;
      px_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if ((state == LOCKED) && va2 && ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM)) begin
        wr_en   <= 1'b1;
        px_x    <= x;
        px_y    <= y;
        px_data <= rgb2;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_capture.sv
// ============================================================================
// tb_vga_capture: scoreboard bench for vga_capture on a scaled-down stream
// (40 pclk/line, 12 lines/frame, 24x8 active, capture window 20x6).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_capture;

  localparam int H_TOT = 40, HS_LEN = 4, HA_START = 9, HA_LEN = 24;
  localparam int V_TOT = 12, VS_LEN = 2, VA_START = 3, VA_LEN = 8;
  localparam int MAX_W = 20, MAX_H = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b1, vsync = 1'b1, valid = 1'b0;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        wr_en, locked, lost_lock;
  logic [9:0]  px_x, px_y, h_total_meas, v_total_meas, h_active_meas, v_active_meas;
  logic [11:0] px_data;

  vga_capture #(.MAX_W(MAX_W), .MAX_H(MAX_H), .LOCK_FRAMES(2), .TIMEOUT(1023)) dut (
    .pclk(clk), .reset(rst_n), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
    .h_active_meas(h_active_meas), .v_active_meas(v_active_meas),
    .locked(locked), .lost_lock(lost_lock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] d;
    int          t;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0, n_pass = 0;
  int   ll_cnt = 0, ll_wide = 0;
  logic ll_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the next expected pixel and time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lost_lock) begin
        ll_cnt++;
        if (ll_prev) ll_wide++;
      end
      ll_prev = lost_lock;
      if (wr_en) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got x=%0d y=%0d data=%0h expected no write",
                   px_x, px_y, px_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pixel {x,y,data,cycle}", {px_x, px_y, px_data, cyc}, {e.x, e.y, e.d, e.t});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
      vga_r = '0; vga_g = '0; vga_b = '0;
    end
  endtask

  // Drives one frame; cut >= 0 stops after two cycles of that line.
  task automatic drive_frame(input int lines, input bit exp_wr, input int cut);
    int px, py;
    logic [11:0] ed;
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < H_TOT; c++) begin
        if (l == cut && c == 2) return;
        @(negedge clk);
        hsync = (c >= HS_LEN);
        vsync = (l >= VS_LEN);
        valid = (l >= VA_START) && (l < VA_START + VA_LEN) &&
                (c >= HA_START) && (c < HA_START + HA_LEN);
        vga_r = '0; vga_g = '0; vga_b = '0;
        if (valid) begin
          px = c - HA_START;
          py = l - VA_START;
          if (px == 10 && py == 3) begin
            vga_r = 8'hA5; vga_g = 8'h3C; vga_b = 8'hF0;
            ed = 12'hA3F;
          end else begin
            vga_r = {px[3:0], 4'hA};
            vga_g = {py[3:0], 4'h5};
            vga_b = {px[3:0] ^ py[3:0], 4'hC};
            ed = {px[3:0], py[3:0], px[3:0] ^ py[3:0]};
          end
          if (exp_wr && px < MAX_W && py < MAX_H)
            q.push_back('{10'(px), 10'(py), ed, cyc + 3});
        end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_px_state", {wr_en, px_x, px_y, px_data, locked, lost_lock}, 64'd0);
    check("reset_meas", {h_total_meas, v_total_meas, h_active_meas, v_active_meas}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(5);

    repeat (3) drive_frame(V_TOT, 1'b0, -1);
    check("locked_before_4th_vsync", locked, 0);
    drive_frame(V_TOT, 1'b1, -1);
    check("locked_after_4th_vsync", locked, 1);
    check("h_total_meas", h_total_meas, 40);
    check("v_total_meas", v_total_meas, 12);
    check("h_active_meas", h_active_meas, 24);
    check("v_active_meas", v_active_meas, 8);

    drive_frame(V_TOT, 1'b1, -1);
    drive_frame(V_TOT - 1, 1'b1, -1);
    check("locked_during_short_frame", locked, 1);
    drive_frame(V_TOT, 1'b0, -1);
    check("locked_after_short_frame", locked, 0);
    check("v_total_short", v_total_meas, 11);
    check("lost_lock_pulses_1", ll_cnt, 1);
    drive_frame(V_TOT, 1'b0, -1);
    drive_frame(V_TOT, 1'b0, -1);
    check("not_yet_relocked", locked, 0);
    drive_frame(V_TOT, 1'b1, -1);
    check("relocked", locked, 1);
    check("v_total_restored", v_total_meas, 12);

    drive_frame(V_TOT, 1'b1, 5);
    check("locked_before_reset", locked, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_px_state", {wr_en, px_x, px_y, px_data, locked, lost_lock}, 64'd0);
    check("async_reset_meas", {h_total_meas, v_total_meas, h_active_meas, v_active_meas}, 64'd0);
    idle(3);
    @(negedge clk) rst_n = 1'b1;
    idle(5);
    repeat (3) drive_frame(V_TOT, 1'b0, -1);
    check("post_reset_not_locked", locked, 0);
    drive_frame(V_TOT, 1'b1, -1);
    check("post_reset_relocked", locked, 1);

    idle(1100);
    check("timeout_unlocks", locked, 0);
    check("lost_lock_pulses_2", ll_cnt, 2);
    repeat (2) drive_frame(V_TOT, 1'b0, -1);
    idle(5);
    check("scoreboard_drained", q.size(), 0);
    check("lost_lock_single_cycle", ll_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
